buzzer_cmd_sequencer: RTL

Timed command queue that sits directly upstream of the buzzer block's 24-bit command port (`start`/`in[23:0]`). The CPU pushes buzzer commands into a circular FIFO, and the sequencer replays them to the buzzer as one-cycle `start` pulses. It also interprets a local WAIT opcode that stalls the stream for a programmed number of ticks. This lets note and sample sequences play without per-note CPU timing.

---
 rtl/buzzer_cmd_sequencer_if.sv | 28 ++
 rtl/buzzer_cmd_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/buzzer_cmd_sequencer_if.sv
// Command-port bundle between the CPU-side writer and the buzzer command sequencer.
// The master drives pushes and flush; the slave (sequencer) drives status and the buzzer strobe.
interface buzzer_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 16
) ();
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [23:0]   wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          busy;
  logic          start;
  logic [23:0]   out;

  modport master (
    output wr_en, wr_data, flush,
    input  full, empty, level, overflow, busy, start, out
  );

  modport slave (
    input  wr_en, wr_data, flush,
    output full, empty, level, overflow, busy, start, out
  );
endinterface

// File: rtl/buzzer_cmd_sequencer.sv
// Timed command queue feeding the buzzer's 24-bit command port. Commands are pushed into a
// circular FIFO and replayed as one-cycle start strobes; WAIT_OP words stall the stream for
// N * TICK_DIV cycles instead of being forwarded.
module buzzer_cmd_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 50000,
  parameter logic [7:0]  WAIT_OP  = 8'hF0
) (
  input logic                  clk,
  input logic                  rst,
  buzzer_cmd_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  logic [23:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  state_e        r_state;
  logic [23:0]   r_cmd;
  logic [15:0]   r_wait;
  logic [PW-1:0] r_presc;
  logic          r_start;
  logic [23:0]   r_out;
  logic          r_overflow;

  logic          w_pop;
  logic          w_push;
  logic [23:0]   w_head;
  logic          w_head_is_wait;

  // Pop/push decisions; flush blocks both, and a full FIFO still accepts when a pop frees a slot.
  always_comb begin
    w_head         = r_mem[r_rptr];
    w_head_is_wait = (w_head[23:16] == WAIT_OP);
    w_pop          = (r_state == StIdle) && (r_count != '0) && !bus.flush;
    w_push         = bus.wr_en && !bus.flush && ((r_count != CW'(DEPTH)) || w_pop);
  end

  // FIFO storage; no reset needed since reads are guarded by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.wr_data;
    end
  end

  // Queue bookkeeping and the IDLE/ISSUE/WAIT sequencer. The strobe is registered on the pop so
  // it is presented during the ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_state    <= StIdle;
      r_cmd      <= '0;
      r_wait     <= '0;
      r_presc    <= '0;
      r_start    <= 1'b0;
      r_out      <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_state    <= StIdle;
      r_cmd      <= '0;
      r_wait     <= '0;
      r_presc    <= '0;
      r_start    <= 1'b0;
      r_out      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (bus.wr_en && !w_push) begin
        r_overflow <= 1'b1;
      end

      r_start <= 1'b0;
      r_out   <= '0;
      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_cmd   <= w_head;
            r_state <= StIssue;
            if (!w_head_is_wait) begin
              r_start <= 1'b1;
              r_out   <= w_head;
            end
          end
        end
        StIssue: begin
          // A zero-length wait is a NOP and goes straight back to IDLE.
          if ((r_cmd[23:16] != WAIT_OP) || (r_cmd[15:0] == 16'd0)) begin
            r_state <= StIdle;
          end else begin
            r_wait  <= r_cmd[15:0];
            r_presc <= '0;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (r_presc == PW'(TICK_DIV - 1)) begin
            r_presc <= '0;
            r_wait  <= r_wait - 16'd1;
            if (r_wait == 16'd1) begin
              r_state <= StIdle;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Status flags come from the registered count; the strobe is suppressed in a flush cycle.
  always_comb begin
    bus.full     = (r_count == CW'(DEPTH));
    bus.empty    = (r_count == '0);
    bus.level    = r_count;
    bus.overflow = r_overflow;
    bus.busy     = (r_state == StWait);
    bus.start    = r_start && !bus.flush;
    bus.out      = bus.flush ? 24'd0 : r_out;
  end
endmodule
